// File: rtl/stream_ready_delay.sv
// stream_ready_delay: consumer-side back-pressure injector for a valid/ready
// stream. Each beat is parked in a one-entry register and presented
// downstream. After the downstream handshake, ready_o is held low for a
// fixed or LFSR-driven number of cycles. With no delay configured, the block
// collapses to plain wires.
module stream_ready_delay #(
  parameter bit          StallRandom = 1'b0,
  parameter int          FixedDelay  = 1,
  parameter type         payload_t   = logic,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     clr_i,
  input  payload_t payload_i,
  input  logic     valid_i,
  output logic     ready_o,
  output payload_t payload_o,
  output logic     valid_o,
  input  logic     ready_i
);

  // Reject configurations the 4-bit stall counter or the LFSR cannot honour
  if (FixedDelay < 0 || FixedDelay > 15) begin : g_bad_delay
    $error("stream_ready_delay: FixedDelay must be within 0..15");
  end
  if (LfsrSeed == 16'h0000) begin : g_bad_seed
    $error("stream_ready_delay: LfsrSeed must be nonzero");
  end

  if (FixedDelay == 0 && !StallRandom) begin : g_pass
    // No stall can ever be requested, so the stream is wired straight through
    logic w_unusedOk;

    assign w_unusedOk = ^{clk_i, rst_ni, clr_i};
    assign ready_o    = ready_i;
    assign valid_o    = valid_i;
    assign payload_o  = payload_i;

  end else begin : g_reg
    typedef enum logic [1:0] {
      Empty = 2'd0,
      Full  = 2'd1,
      Stall = 2'd2
    } state_t;

    localparam logic [3:0] FixedDelayBits = 4'(FixedDelay);

    state_t      r_state;
    payload_t    r_data;
    logic [3:0]  r_cnt;
    logic [15:0] r_lfsr;
    logic [3:0]  w_delay;
    logic [15:0] w_lfsrNext;
    logic        w_outHs;

    // The stall length for the beat currently on the output is taken from
    // the LFSR value that is live during its handshake
    assign w_delay    = StallRandom ? r_lfsr[3:0] : FixedDelayBits;
    assign w_lfsrNext = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_outHs    = valid_o && ready_i;

    // Outputs are decoded from the registered state. In Full with a zero
    // stall, ready_o follows ready_i so a new beat can replace the departing
    // one in the same cycle.
    assign valid_o   = (r_state == Full);
    assign ready_o   = (r_state == Empty) ||
                       ((r_state == Full) && ready_i && (w_delay == 4'd0));
    assign payload_o = r_data;

    // Buffer/stall sequencing; reset and clear override every handshake
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
        r_state <= Empty;
        r_cnt   <= 4'd0;
        r_lfsr  <= LfsrSeed;
        r_data  <= '0;
      end else begin
        if (w_outHs) begin
          r_lfsr <= w_lfsrNext;
        end
        case (r_state)
          Empty: begin
            if (valid_i) begin
              r_data  <= payload_i;
              r_state <= Full;
            end
          end
          Full: begin
            if (ready_i) begin
              if (w_delay == 4'd0) begin
                if (valid_i) begin
                  r_data <= payload_i;
                end else begin
                  r_state <= Empty;
                end
              end else begin
                r_cnt   <= w_delay;
                r_state <= Stall;
              end
            end
          end
          Stall: begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= Empty;
            end
          end
          default: begin
            r_state <= Empty;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_ready_delay.sv
// Directed bench for stream_ready_delay: four instances cover pass-through,
// fixed delays of 3 and 1, and LFSR-driven stalls.
module tb_stream_ready_delay;

  typedef logic [7:0] pay_t;

  logic clk;
  logic rstN;
  logic clrI;

  pay_t ptPayI, ptPayO, f3PayI, f3PayO, f1PayI, f1PayO, rnPayI, rnPayO;
  logic ptValI, ptValO, ptRdyI, ptRdyO;
  logic f3ValI, f3ValO, f3RdyI, f3RdyO;
  logic f1ValI, f1ValO, f1RdyI, f1RdyO;
  logic rnValI, rnValO, rnRdyI, rnRdyO;

  int nVectors;
  int nMiscompares;

  stream_ready_delay #(.StallRandom(1'b0), .FixedDelay(0), .payload_t(pay_t), .LfsrSeed(16'hACE1)) uPass (
    .clk_i(clk), .rst_ni(rstN), .clr_i(clrI), .payload_i(ptPayI), .valid_i(ptValI),
    .ready_o(ptRdyO), .payload_o(ptPayO), .valid_o(ptValO), .ready_i(ptRdyI));

  stream_ready_delay #(.StallRandom(1'b0), .FixedDelay(3), .payload_t(pay_t), .LfsrSeed(16'hACE1)) uFix3 (
    .clk_i(clk), .rst_ni(rstN), .clr_i(clrI), .payload_i(f3PayI), .valid_i(f3ValI),
    .ready_o(f3RdyO), .payload_o(f3PayO), .valid_o(f3ValO), .ready_i(f3RdyI));

  stream_ready_delay #(.StallRandom(1'b0), .FixedDelay(1), .payload_t(pay_t), .LfsrSeed(16'hACE1)) uFix1 (
    .clk_i(clk), .rst_ni(rstN), .clr_i(clrI), .payload_i(f1PayI), .valid_i(f1ValI),
    .ready_o(f1RdyO), .payload_o(f1PayO), .valid_o(f1ValO), .ready_i(f1RdyI));

  stream_ready_delay #(.StallRandom(1'b1), .FixedDelay(1), .payload_t(pay_t), .LfsrSeed(16'hACE1)) uRand (
    .clk_i(clk), .rst_ni(rstN), .clr_i(clrI), .payload_i(rnPayI), .valid_i(rnValI),
    .ready_o(rnRdyO), .payload_o(rnPayO), .valid_o(rnValO), .ready_i(rnRdyI));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset leaves every registered instance Empty
  task automatic test_reset();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    #1;
    nVectors += 6;
    if (f3ValO !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_f3_valid: got %b expected 0", f3ValO); end
    if (f3RdyO !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_f3_ready: got %b expected 1", f3RdyO); end
    if (f1ValO !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_f1_valid: got %b expected 0", f1ValO); end
    if (f1RdyO !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_f1_ready: got %b expected 1", f1RdyO); end
    if (rnValO !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_rnd_valid: got %b expected 0", rnValO); end
    if (rnRdyO !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_rnd_ready: got %b expected 1", rnRdyO); end
    tick();
  endtask

  // Zero-delay configuration behaves as wires
  task automatic test_passthrough();
    for (int c = 0; c < 24; c++) begin
      ptValI = 1'($urandom);
      ptRdyI = 1'($urandom);
      ptPayI = 8'($urandom);
      #1;
      nVectors += 3;
      if (ptRdyO !== ptRdyI) begin nMiscompares++; $display("[TB] FAIL pass_ready c%0d: got %b expected %b", c, ptRdyO, ptRdyI); end
      if (ptValO !== ptValI) begin nMiscompares++; $display("[TB] FAIL pass_valid c%0d: got %b expected %b", c, ptValO, ptValI); end
      if (ptPayO !== ptPayI) begin nMiscompares++; $display("[TB] FAIL pass_payload c%0d: got %h expected %h", c, ptPayO, ptPayI); end
      tick();
    end
    ptValI = 1'b0;
    ptRdyI = 1'b0;
  endtask

  // Delay 3 with ready_i high: beats accepted at cycles 0 and 5
  task automatic test_fixed3();
    bit   expR[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit   expV[11] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    pay_t expP[11] = '{8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    f3RdyI = 1'b1;
    for (int c = 0; c < 11; c++) begin
      f3ValI = (c <= 5);
      f3PayI = (c == 0) ? 8'h11 : 8'h22;
      #1;
      nVectors += 2;
      if (f3RdyO !== expR[c]) begin nMiscompares++; $display("[TB] FAIL fix3_ready c%0d: got %b expected %b", c, f3RdyO, expR[c]); end
      if (f3ValO !== expV[c]) begin nMiscompares++; $display("[TB] FAIL fix3_valid c%0d: got %b expected %b", c, f3ValO, expV[c]); end
      if (expV[c]) begin
        nVectors++;
        if (f3PayO !== expP[c]) begin nMiscompares++; $display("[TB] FAIL fix3_payload c%0d: got %h expected %h", c, f3PayO, expP[c]); end
      end
      tick();
    end
    f3ValI = 1'b0;
    f3RdyI = 1'b0;
  endtask

  // Delay 1 with downstream back-pressure: beat held stable, then one stall
  task automatic test_fixed1_hold();
    bit expR[8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    bit expV[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    for (int c = 0; c < 8; c++) begin
      f1ValI = (c == 0);
      f1PayI = (c == 0) ? 8'h5A : 8'hEE;
      f1RdyI = (c >= 5);
      #1;
      nVectors += 2;
      if (f1RdyO !== expR[c]) begin nMiscompares++; $display("[TB] FAIL fix1_ready c%0d: got %b expected %b", c, f1RdyO, expR[c]); end
      if (f1ValO !== expV[c]) begin nMiscompares++; $display("[TB] FAIL fix1_valid c%0d: got %b expected %b", c, f1ValO, expV[c]); end
      if (expV[c]) begin
        nVectors++;
        if (f1PayO !== 8'h5A) begin nMiscompares++; $display("[TB] FAIL fix1_payload c%0d: got %h expected 5a", c, f1PayO); end
      end
      tick();
    end
    f1ValI = 1'b0;
    f1RdyI = 1'b0;
  endtask

  // Clear in Full and in Stall; the LFSR restarts so D is seed[3:0]=1 again
  task automatic test_clear();
    logic clrV[9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    logic valV[9] = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
    pay_t payV[9] = '{8'hA5, 8'h00, 8'hB6, 8'h00, 8'h00, 8'hC7, 8'h00, 8'h00, 8'h00};
    logic rdyV[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    bit   expR[9] = '{1, 0, 1, 0, 0, 1, 0, 0, 1};
    bit   expV[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
    pay_t expP[9] = '{8'h00, 8'hA5, 8'h00, 8'hB6, 8'h00, 8'h00, 8'hC7, 8'h00, 8'h00};
    clrI   = 1'b1;
    rnValI = 1'b0;
    rnRdyI = 1'b0;
    tick();
    for (int c = 0; c < 9; c++) begin
      clrI   = clrV[c];
      rnValI = valV[c];
      rnPayI = payV[c];
      rnRdyI = rdyV[c];
      #1;
      nVectors += 2;
      if (rnRdyO !== expR[c]) begin nMiscompares++; $display("[TB] FAIL clear_ready c%0d: got %b expected %b", c, rnRdyO, expR[c]); end
      if (rnValO !== expV[c]) begin nMiscompares++; $display("[TB] FAIL clear_valid c%0d: got %b expected %b", c, rnValO, expV[c]); end
      if (expV[c]) begin
        nVectors++;
        if (rnPayO !== expP[c]) begin nMiscompares++; $display("[TB] FAIL clear_payload c%0d: got %h expected %h", c, rnPayO, expP[c]); end
      end
      tick();
    end
    clrI   = 1'b0;
    rnValI = 1'b0;
    rnRdyI = 1'b0;
  endtask

  // 1000 beats with random handshakes, scoreboarded against a software LFSR
  task automatic test_random();
    logic [15:0] model = 16'hACE1;
    pay_t        sb[$];
    pay_t        nextPay;
    pay_t        expPay;
    logic [3:0]  d;
    int          got = 0;
    int          cycles = 0;
    int          stallLeft = 0;
    bit          expEmpty = 1'b0;
    clrI = 1'b1;
    tick();
    clrI = 1'b0;
    nextPay = 8'($urandom);
    while (got < 1000 && cycles < 30000) begin
      rnValI = ($urandom_range(0, 9) < 7);
      rnRdyI = ($urandom_range(0, 9) < 7);
      rnPayI = nextPay;
      #1;
      if (stallLeft > 0) begin
        nVectors++;
        if (rnValO !== 1'b0 || rnRdyO !== 1'b0) begin
          nMiscompares++;
          $display("[TB] FAIL rnd_stall cyc%0d: got valid=%b ready=%b expected valid=0 ready=0", cycles, rnValO, rnRdyO);
        end
        stallLeft--;
        if (stallLeft == 0) expEmpty = 1'b1;
      end else if (expEmpty) begin
        nVectors++;
        if (rnValO !== 1'b0 || rnRdyO !== 1'b1) begin
          nMiscompares++;
          $display("[TB] FAIL rnd_empty cyc%0d: got valid=%b ready=%b expected valid=0 ready=1", cycles, rnValO, rnRdyO);
        end
        expEmpty = 1'b0;
      end
      if (rnValO === 1'b1 && rnRdyI) begin
        nVectors += 2;
        if (sb.size() == 0) begin
          nMiscompares++;
          $display("[TB] FAIL rnd_spurious cyc%0d: got valid=1 expected no beat pending", cycles);
        end else begin
          expPay = sb.pop_front();
          if (rnPayO !== expPay) begin nMiscompares++; $display("[TB] FAIL rnd_payload beat%0d: got %h expected %h", got, rnPayO, expPay); end
        end
        d = model[3:0];
        if (rnRdyO !== (d == 4'd0)) begin
          nMiscompares++;
          $display("[TB] FAIL rnd_stall_len beat%0d: got ready=%b expected %b (D=%0d)", got, rnRdyO, (d == 4'd0), d);
        end
        model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
        stallLeft = int'(d);
        got++;
      end
      if (rnValI && rnRdyO === 1'b1) begin
        sb.push_back(nextPay);
        nextPay = 8'($urandom);
      end
      tick();
      cycles++;
    end
    nVectors++;
    if (got < 1000) begin
      nMiscompares++;
      $display("[TB] FAIL rnd_timeout: got %0d beats expected 1000", got);
    end
    rnValI = 1'b0;
    rnRdyI = 1'b0;
  endtask

  // Reset mid-Full coinciding with valid_i: beat dropped, next beat clean
  task automatic test_reset_mid();
    logic rstV[9] = '{1, 0, 1, 1, 1, 1, 1, 1, 1};
    logic valV[9] = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
    pay_t payV[9] = '{8'h33, 8'h44, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic rdyV[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
    bit   expR[9] = '{1, 0, 1, 1, 0, 0, 0, 0, 1};
    bit   expV[9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    pay_t expP[9] = '{8'h00, 8'h33, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int c = 0; c < 9; c++) begin
      rstN   = rstV[c];
      f3ValI = valV[c];
      f3PayI = payV[c];
      f3RdyI = rdyV[c];
      #1;
      nVectors += 2;
      if (f3RdyO !== expR[c]) begin nMiscompares++; $display("[TB] FAIL rstmid_ready c%0d: got %b expected %b", c, f3RdyO, expR[c]); end
      if (f3ValO !== expV[c]) begin nMiscompares++; $display("[TB] FAIL rstmid_valid c%0d: got %b expected %b", c, f3ValO, expV[c]); end
      if (expV[c]) begin
        nVectors++;
        if (f3PayO !== expP[c]) begin nMiscompares++; $display("[TB] FAIL rstmid_payload c%0d: got %h expected %h", c, f3PayO, expP[c]); end
      end
      tick();
    end
    rstN   = 1'b1;
    f3ValI = 1'b0;
    f3RdyI = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    rstN   = 1'b0;
    clrI   = 1'b0;
    ptPayI = '0; ptValI = 1'b0; ptRdyI = 1'b0;
    f3PayI = '0; f3ValI = 1'b0; f3RdyI = 1'b0;
    f1PayI = '0; f1ValI = 1'b0; f1RdyI = 1'b0;
    rnPayI = '0; rnValI = 1'b0; rnRdyI = 1'b0;
    tick();
    test_reset();
    test_passthrough();
    test_fixed3();
    test_fixed1_hold();
    test_clear();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/stream_ready_delay.md
Name: stream_ready_delay

Overview:
Receiver-side counterpart of the valid-delay stage. It accepts each beat into a one-entry register, presents the beat downstream, and then holds ready_o low for a fixed or pseudo-random number of cycles. Testbenches and debug builds insert it at the consumer end of any valid/ready stream to inject back-pressure. There is no combinational path from valid_i to valid_o.

Parameters:
StallRandom, 0, 1: the post-handshake stall length is drawn from an internal LFSR. 0: the stall length is FixedDelay.
FixedDelay, 1, stall cycles after each output handshake. Legal range is 0..15. Elaboration fails if it is outside that range.
payload_t, logic, payload type.
LfsrSeed, 16'hACE1, LFSR reset and clear value. Must be nonzero; elaboration fails on 0.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
clr_i  input  1  synchronous clear, same effect as reset
payload_i  input  payload_t  upstream data
valid_i  input  1  upstream valid
ready_o  output  1  upstream ready
payload_o  output  payload_t  downstream data
valid_o  output  1  downstream valid
ready_i  input  1  downstream ready

Behaviour:
- Pass-through when FixedDelay==0 && !StallRandom:
  - ready_o=ready_i, valid_o=valid_i, payload_o=payload_i.
  - No state is instantiated.
- Otherwise, FSM states Empty, Full, Stall.
  - Registers: data_q (payload_t), cnt_q (4 bits), lfsr_q (16 bits).
- Delay value D:
  - StallRandom=1: D = lfsr_q[3:0].
  - StallRandom=0: D = FixedDelay.
- LFSR:
  - Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left, feedback into bit 0.
  - Advances exactly one step per output handshake (valid_o && ready_i), and at no other time.
- Empty:
  - Outputs: valid_o=0, ready_o=1.
  - On valid_i: data_q<=payload_i, go to Full.
- Full:
  - Outputs: valid_o=1, payload_o=data_q. ready_o = ready_i && (D==0).
  - ready_i=0: hold. data_q and payload_o must stay stable.
  - ready_i=1 and D==0:
    - valid_i=1: capture the new beat the same cycle and stay in Full. This gives full throughput.
    - valid_i=0: go to Empty.
  - ready_i=1 and D>0: cnt_q<=D, go to Stall.
- Stall:
  - Outputs: valid_o=0, ready_o=0.
  - cnt_q decrements every cycle. When cnt_q==1, go to Empty next cycle.
  - The block therefore spends exactly D cycles in Stall.
- Upstream beat spacing with ready_i held high:
  - D>0: 2+D cycles between beats.
  - D==0: 1 cycle between beats.
- payload_o equals data_q in all registered-mode states. It is only meaningful while valid_o=1.
- Reset (rst_ni=0 at a clock edge):
  - State<=Empty, cnt_q<=0, lfsr_q<=LfsrSeed, data_q<='0.
  - Outputs after that edge: valid_o=0, ready_o=1.
  - Reset asserted during Full or Stall discards the buffered beat with no output handshake.
- clr_i=1 at a clock edge: identical to reset. clr_i has priority over every handshake in that cycle.
- Simultaneous reset/clr_i and valid_i: the beat is not accepted and the LFSR does not advance.
- The block never issues valid_o without a previously accepted beat. Every accepted beat produces exactly one output handshake unless it is discarded by reset or clear.

Test Plan:
- Pass-through (FixedDelay=0, StallRandom=0): toggle ready_i and valid_i randomly -> ready_o==ready_i and valid_o==valid_i in the same cycle, and payload_o==payload_i at all times.
- FixedDelay=3, ready_i=1, valid_i=1 with A then B -> A accepted cycle 0; valid_o=1 with payload A in cycle 1; ready_o=0 in cycles 1-4; B accepted cycle 5; B on output cycle 6.
- FixedDelay=1, hold ready_i=0 for 4 cycles after A is captured -> valid_o=1 and payload_o=A stable for 4 cycles with ready_o=0. Raise ready_i -> handshake, 1 stall cycle, then Empty.
- StallRandom=1, LfsrSeed=16'hACE1, 1000 beats with random valid_i/ready_i -> output order and data match the input with no loss or duplication. Each stall length matches a software LFSR model. Beats with D==0 show back-to-back acceptance.
- clr_i pulsed in Full and again in Stall -> the next cycle is Empty with valid_o=0 and ready_o=1. The buffered beat is never emitted, and the next D restarts from LfsrSeed.
- rst_ni low for one cycle mid-Full, asserted together with valid_i -> the beat is not accepted, state is Empty, cnt_q=0, and the sequence resumes cleanly.
